// File: rtl/fpu_vec_normalize.sv
// fpu_vec_normalize: scales a latched half-precision 3-vector by the
// reciprocal square root delivered by fastInvSqrt, one component per cycle
// on a single shared half-precision multiplier.
module fpu_vec_normalize #(
  parameter int          TIMEOUT = 255,
  parameter logic [15:0] NAN_OUT = 16'h7E00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] xin,
  input  logic [15:0] yin,
  input  logic [15:0] zin,
  input  logic        rsq_valid,
  input  logic [15:0] rsq,
  input  logic [1:0]  rsq_ofuf,
  output logic        busy,
  output logic        out_valid,
  output logic [1:0]  out_idx,
  output logic [15:0] out_data,
  output logic [1:0]  OFUF,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, WAIT_RSQ, MUL0, MUL1, MUL2} state_t;

  localparam logic [15:0] TO = 16'(TIMEOUT);

  state_t      state;
  logic [15:0] xr, yr, zr, rr;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;

  logic [15:0] opa;
  logic [15:0] prod;
  logic [1:0]  pflags;

  logic        sign;
  logic [4:0]  ea, eb;
  logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic [10:0] siga, sigb;
  logic [21:0] p;
  logic [9:0]  mant;
  logic        guard, sticky;
  logic [10:0] mr;
  logic [6:0]  esum;
  logic [4:0]  efin;

  assign cnt_inc = cnt + 16'd1;

  // Select the component that the multiplier works on this cycle.
  always_comb begin
    opa = '0;
    case (state)
      MUL0:    opa = xr;
      MUL1:    opa = yr;
      MUL2:    opa = zr;
      default: opa = '0;
    endcase
  end

  // Half-precision multiply of the selected component by the latched rsq.
  // esum carries the +15 bias offset so overflow/underflow tests stay unsigned:
  // final exponent = esum - 15, so >=31 means esum>=46 and <=0 means esum<=15.
  always_comb begin
    prod   = '0;
    pflags = '0;
    sign   = opa[15] ^ rr[15];
    ea     = opa[14:10];
    eb     = rr[14:10];
    a_nan  = (&ea) && (|opa[9:0]);
    a_inf  = (&ea) && !(|opa[9:0]);
    a_zero = !(|ea);
    b_nan  = (&eb) && (|rr[9:0]);
    b_inf  = (&eb) && !(|rr[9:0]);
    b_zero = !(|eb);
    siga   = {1'b1, opa[9:0]};
    sigb   = {1'b1, rr[9:0]};
    p      = {11'd0, siga} * {11'd0, sigb};
    if (p[21]) begin
      mant   = p[20:11];
      guard  = p[10];
      sticky = |p[9:0];
    end else begin
      mant   = p[19:10];
      guard  = p[9];
      sticky = |p[8:0];
    end
    mr   = {1'b0, mant} + {10'd0, guard & (sticky | mant[0])};
    esum = {2'b00, ea} + {2'b00, eb} + {6'd0, p[21]} + {6'd0, mr[10]};
    efin = esum[4:0] - 5'd15;

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      prod = NAN_OUT;
    end else if (a_inf || b_inf) begin
      prod = {sign, 5'h1F, 10'd0};
    end else if (a_zero || b_zero) begin
      prod = {sign, 15'd0};
    end else if (esum >= 7'd46) begin
      prod   = {sign, 5'h1F, 10'd0};
      pflags = 2'b10;
    end else if (esum <= 7'd15) begin
      prod   = {sign, 15'd0};
      pflags = 2'b01;
    end else begin
      prod = {sign, efin, mr[9:0]};
    end
  end

  // Control sequence, operand/rsq latches, timeout counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      xr        <= '0;
      yr        <= '0;
      zr        <= '0;
      rr        <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      OFUF      <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xr    <= xin;
            yr    <= yin;
            zr    <= zin;
            OFUF  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= WAIT_RSQ;
          end
        end
        WAIT_RSQ: begin
          if (rsq_valid) begin
            rr    <= rsq;
            OFUF  <= OFUF | rsq_ofuf;
            state <= MUL0;
          end else if ((TIMEOUT != 0) && (cnt_inc == TO)) begin
            cnt   <= cnt_inc;
            done  <= 1'b1;
            OFUF  <= 2'b11;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        MUL0: begin
          out_valid <= 1'b1;
          out_idx   <= 2'd0;
          out_data  <= prod;
          OFUF      <= OFUF | pflags;
          state     <= MUL1;
        end
        MUL1: begin
          out_valid <= 1'b1;
          out_idx   <= 2'd1;
          out_data  <= prod;
          OFUF      <= OFUF | pflags;
          state     <= MUL2;
        end
        MUL2: begin
          out_valid <= 1'b1;
          out_idx   <= 2'd2;
          out_data  <= prod;
          OFUF      <= OFUF | pflags;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_vec_normalize.sv
// Testbench for fpu_vec_normalize: directed and randomized vectors checked
// against an arithmetic model of half-precision multiply.
module tb_fpu_vec_normalize;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] xin, yin, zin;
  logic        rsq_valid;
  logic [15:0] rsq;
  logic [1:0]  rsq_ofuf;
  logic        busy;
  logic        out_valid;
  logic [1:0]  out_idx;
  logic [15:0] out_data;
  logic [1:0]  OFUF;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [15:0] got [3];
  logic [1:0]  gotflags;

  always #5 clk = ~clk;

  fpu_vec_normalize #(.TIMEOUT(255), .NAN_OUT(16'h7E00)) dut (
    .clk(clk), .reset(reset), .start(start),
    .xin(xin), .yin(yin), .zin(zin),
    .rsq_valid(rsq_valid), .rsq(rsq), .rsq_ofuf(rsq_ofuf),
    .busy(busy), .out_valid(out_valid), .out_idx(out_idx),
    .out_data(out_data), .OFUF(OFUF), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference multiply: {flags[1:0], result[15:0]} from exact integer arithmetic.
  function automatic logic [17:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int     ea, eb, ma, mb, e, sh;
    longint p, q, rem, half, pw;
    logic   s, an, bn, ai, bi, az, bz;
    ea = int'(a[14:10]); ma = int'(a[9:0]);
    eb = int'(b[14:10]); mb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    an = (ea == 31) && (ma != 0); bn = (eb == 31) && (mb != 0);
    ai = (ea == 31) && (ma == 0); bi = (eb == 31) && (mb == 0);
    az = (ea == 0);               bz = (eb == 0);
    if (an || bn) return {2'b00, 16'h7E00};
    if ((ai && bz) || (bi && az)) return {2'b00, 16'h7E00};
    if (ai || bi) return {2'b00, s, 5'h1F, 10'h000};
    if (az || bz) return {2'b00, s, 15'h0000};
    p    = longint'(1024 + ma) * longint'(1024 + mb);
    sh   = (p >= 2097152) ? 11 : 10;
    e    = ea + eb - 15 + (sh - 10);
    pw   = longint'(1) << sh;
    q    = p / pw;
    rem  = p % pw;
    half = pw / 2;
    if (rem > half || (rem == half && (q % 2) == 1)) q++;
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    if (e >= 31) return {2'b10, s, 5'h1F, 10'h000};
    if (e <= 0) return {2'b01, s, 15'h0000};
    return {2'b00, s, 5'(e), 10'(q - 1024)};
  endfunction

  function automatic logic [15:0] rnd_half();
    logic [15:0] sp [6];
    sp[0] = 16'h0000; sp[1] = 16'h8000; sp[2] = 16'h7C00;
    sp[3] = 16'hFC00; sp[4] = 16'h7E00; sp[5] = 16'h0123;
    case ($urandom_range(0, 9))
      0:          return sp[$urandom_range(0, 5)];
      1, 2, 3, 4: return 16'($urandom);
      default:    return {1'($urandom), 5'($urandom_range(10, 22)), 10'($urandom)};
    endcase
  endfunction

  // One full operation: start, d idle WAIT cycles, rsq pulse, three outputs.
  // glitch adds an rsq_valid alongside start and a second start during MUL1.
  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                       input logic [15:0] r, input logic [1:0] f, input int d, input bit glitch);
    logic [17:0] m [3];
    logic [15:0] comp [3];
    logic [1:0]  accf;
    comp[0] = x; comp[1] = y; comp[2] = z;
    accf = f;
    for (int k = 0; k < 3; k++) begin
      m[k] = ref_mul(comp[k], r);
      accf = accf | m[k][17:16];
    end
    @(negedge clk);
    start = 1'b1; xin = x; yin = y; zin = z;
    rsq_valid = glitch; rsq = r ^ 16'h5555; rsq_ofuf = glitch ? 2'b10 : 2'b00;
    @(negedge clk);
    start = 1'b0; rsq_valid = 1'b0; rsq_ofuf = 2'b00;
    xin = ~x; yin = ~y; zin = ~z;
    chk("busy_after_start", busy, 1);
    chk("no_out_after_start", {out_valid, done}, 0);
    repeat (d) begin
      @(negedge clk);
      chk("wait_quiet", {out_valid, done, busy}, 3'b001);
    end
    rsq_valid = 1'b1; rsq = r; rsq_ofuf = f;
    @(negedge clk);
    rsq_valid = 1'b0; rsq_ofuf = 2'b00; rsq = ~r;
    chk("no_out_at_e0", out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (glitch && k == 0) begin
        start = 1'b1; xin = 16'h1234; yin = 16'h4321; zin = 16'h3C00;
      end else begin
        start = 1'b0;
      end
      got[k] = out_data;
      chk($sformatf("out_valid%0d", k), out_valid, 1);
      chk($sformatf("out_idx%0d", k), out_idx, k);
      chk($sformatf("out_data%0d", k), out_data, m[k][15:0]);
      chk($sformatf("done%0d", k), done, (k == 2));
      chk($sformatf("busy%0d", k), busy, (k != 2));
    end
    gotflags = OFUF;
    chk("ofuf_end", OFUF, accf);
    @(negedge clk);
    chk("post_quiet", {out_valid, done, busy}, 0);
    chk("out_data_held", out_data, m[2][15:0]);
    chk("ofuf_held", OFUF, accf);
  endtask

  initial begin
    int          cycles;
    bit          got_done, seen_ov;
    logic [1:0]  to_flags;
    logic        to_busy;

    reset = 1'b0; start = 1'b0; xin = '0; yin = '0; zin = '0;
    rsq_valid = 1'b0; rsq = '0; rsq_ofuf = '0;
    #12;
    chk("rst_outputs", {busy, out_valid, done, out_idx, OFUF}, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    reset = 1'b1;

    // (3,4,0) scaled by 1/5
    do_op(16'h4200, 16'h4400, 16'h0000, 16'h3266, 2'b00, 2, 1'b0);
    chk("vec_x_tie_even", got[0], 16'h38CC);
    chk("vec_y", got[1], 16'h3A66);
    chk("vec_z", got[2], 16'h0000);
    chk("vec_flags", gotflags, 2'b00);

    // overflow, then underflow in a fresh op
    do_op(16'h7800, 16'h3C00, 16'h0000, 16'h4000, 2'b00, 1, 1'b0);
    chk("of_out", got[0], 16'h7C00);
    chk("of_flags", gotflags, 2'b10);
    do_op(16'h0400, 16'h0000, 16'h0000, 16'h3800, 2'b00, 0, 1'b0);
    chk("uf_out", got[0], 16'h0000);
    chk("uf_flags", gotflags, 2'b01);

    // NaN / inf special cases
    do_op(16'h7E00, 16'h3C00, 16'h0000, 16'h3C00, 2'b00, 0, 1'b0);
    chk("nan_in", got[0], 16'h7E00);
    chk("nan_flags", gotflags, 2'b00);
    do_op(16'h7C00, 16'h3C00, 16'h0000, 16'h0000, 2'b00, 1, 1'b0);
    chk("inf_x_zero", got[0], 16'h7E00);
    chk("inf_x_zero_flags", gotflags, 2'b00);
    do_op(16'h3C00, 16'h0000, 16'hBC00, 16'h7C00, 2'b00, 0, 1'b0);
    chk("one_x_inf", got[0], 16'h7C00);
    chk("neg_one_x_inf", got[2], 16'hFC00);
    chk("one_x_inf_flags", gotflags, 2'b00);

    // timeout with no rsq_valid
    @(negedge clk);
    start = 1'b1; xin = 16'h3C00; yin = 16'h3C00; zin = 16'h3C00;
    @(negedge clk);
    start = 1'b0;
    cycles = 0; got_done = 0; seen_ov = 0; to_flags = '0; to_busy = 1'b1;
    for (int i = 0; i < 400 && !got_done; i++) begin
      @(negedge clk);
      cycles++;
      if (out_valid) seen_ov = 1;
      if (done) begin
        got_done = 1;
        to_flags = OFUF;
        to_busy  = busy;
      end
    end
    chk("to_done_seen", got_done, 1);
    chk("to_cycles", cycles, 255);
    chk("to_flags", to_flags, 2'b11);
    chk("to_busy", to_busy, 0);
    chk("to_no_out_valid", seen_ov, 0);
    @(negedge clk);
    chk("to_done_pulse", done, 0);

    // ignored rsq_valid in IDLE and start while busy
    do_op(16'h4200, 16'hC400, 16'h3555, 16'h3266, 2'b01, 3, 1'b1);
    chk("glitch_x", got[0], 16'h38CC);
    chk("glitch_flag_uf", gotflags[0], 1);

    // reset during MUL1
    @(negedge clk);
    start = 1'b1; xin = 16'h4200; yin = 16'h4400; zin = 16'h3C00;
    @(negedge clk);
    start = 1'b0; rsq_valid = 1'b1; rsq = 16'h3C00; rsq_ofuf = 2'b11;
    @(negedge clk);
    rsq_valid = 1'b0; rsq_ofuf = 2'b00;
    @(negedge clk);
    chk("pre_rst_out_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    chk("midrst_ctrl", {busy, out_valid, done, out_idx, OFUF}, 0);
    chk("midrst_data", out_data, 0);
    @(negedge clk);
    reset = 1'b1;
    seen_ov = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || done || busy) seen_ov = 1;
    end
    chk("after_rst_quiet", seen_ov, 0);

    // randomized operations
    for (int n = 0; n < 40; n++) begin
      logic [15:0] rx, ry, rz, rr;
      logic [1:0]  rf;
      rx = rnd_half(); ry = rnd_half(); rz = rnd_half();
      if ($urandom_range(0, 4) == 0) rr = rnd_half();
      else rr = {1'b0, 5'($urandom_range(8, 18)), 10'($urandom)};
      rf = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_op(rx, ry, rz, rr, rf, $urandom_range(0, 10), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
